// File: rtl/fft_pkg.sv
// fft_pkg: widths and rounding/saturation helpers shared by the FFT butterfly and twiddle stages
//   round_shift(x): round half-up, then arithmetic shift right by FRAC_W
//   sat(x):         clamp to the signed DATA_W output range
package fft_pkg;
    localparam int DATA_W     = 16;
    localparam int COEFF_W    = 11;
    localparam int FRAC_W     = 9;
    localparam int N_COEFF_S5 = 32;
    localparam int ADDR_W_S5  = $clog2(N_COEFF_S5);
    localparam int PROD_W     = DATA_W + COEFF_W;
    localparam int SUM_W      = PROD_W + 1;
    localparam logic signed [SUM_W-1:0] SAT_MAX = SUM_W'((1 << (DATA_W - 1)) - 1);
    localparam logic signed [SUM_W-1:0] SAT_MIN = ~SAT_MAX;

    function automatic logic signed [SUM_W-1:0] round_shift(input logic signed [SUM_W-1:0] x);
        logic signed [SUM_W-1:0] t;
        t = x + SUM_W'(1 << (FRAC_W - 1));
        return t >>> FRAC_W;
    endfunction

    function automatic logic signed [DATA_W-1:0] sat(input logic signed [SUM_W-1:0] x);
        return (x > SAT_MAX) ? SAT_MAX[DATA_W-1:0] :
               (x < SAT_MIN) ? SAT_MIN[DATA_W-1:0] : x[DATA_W-1:0];
    endfunction
endpackage

// File: rtl/cmult_rnd_sat.sv
// cmult_rnd_sat: two-stage complex multiply (products, then sum/round/saturate)
//   clk, rst (async, active-low)
//   ld             loads the output register; outputs hold otherwise
//   a_re/a_im      data operand, c_re/c_im coefficient operand (presented together)
//   y_re/y_im      registered result, 2 cycles after the operands
//   sat_hit        combinational: the result about to be loaded is saturated
module cmult_rnd_sat
    import fft_pkg::*;
(
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      ld,
    input  logic signed [DATA_W-1:0]  a_re,
    input  logic signed [DATA_W-1:0]  a_im,
    input  logic signed [COEFF_W-1:0] c_re,
    input  logic signed [COEFF_W-1:0] c_im,
    output logic signed [DATA_W-1:0]  y_re,
    output logic signed [DATA_W-1:0]  y_im,
    output logic                      sat_hit
);
    logic signed [PROD_W-1:0] rr, ii, ri, ir;
    logic signed [SUM_W-1:0]  qr, qi;

    always_comb begin
        qr      = round_shift(SUM_W'(rr) - SUM_W'(ii));
        qi      = round_shift(SUM_W'(ri) + SUM_W'(ir));
        sat_hit = (SUM_W'(sat(qr)) != qr) | (SUM_W'(sat(qi)) != qi);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rr   <= '0;
            ii   <= '0;
            ri   <= '0;
            ir   <= '0;
            y_re <= '0;
            y_im <= '0;
        end else begin
            rr <= PROD_W'(a_re) * PROD_W'(c_re);
            ii <= PROD_W'(a_im) * PROD_W'(c_im);
            ri <= PROD_W'(a_re) * PROD_W'(c_im);
            ir <= PROD_W'(a_im) * PROD_W'(c_re);
            if (ld) begin
                y_re <= sat(qr);
                y_im <= sat(qi);
            end
        end
    end
endmodule

// File: rtl/twiddle_mult_5_2.sv
// twiddle_mult_5_2: stage-5 -> stage-6 twiddle multiply of the 128-point FFT
//   clk, rst (async, active-low)
//   din_valid/din_sof/din_re/din_im   input sample stream, no backpressure
//   coeff_addr                        twiddle ROM index (combinational), data back 1 cycle later
//   coeff_in                          {re, im} coefficient, Q1.9 signed
//   dout_valid/dout_sof/dout_re/dout_im  result stream, 3 cycles after input
//   ovf                               sticky per-frame saturation flag
module twiddle_mult_5_2
    import fft_pkg::*;
(
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        din_valid,
    input  logic                        din_sof,
    input  logic signed [DATA_W-1:0]    din_re,
    input  logic signed [DATA_W-1:0]    din_im,
    output logic [ADDR_W_S5-1:0]        coeff_addr,
    input  logic [2*COEFF_W-1:0]        coeff_in,
    output logic                        dout_valid,
    output logic                        dout_sof,
    output logic signed [DATA_W-1:0]    dout_re,
    output logic signed [DATA_W-1:0]    dout_im,
    output logic                        ovf
);
    logic [ADDR_W_S5-1:0]     cnt;
    logic                     v0, s0, v1, s1, sat_hit;
    logic signed [DATA_W-1:0] re0, im0;

    // sof restarts the index immediately so the first sample of a frame reads entry 0
    assign coeff_addr = (din_valid & din_sof) ? '0 : cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt        <= '0;
            v0         <= 1'b0;
            s0         <= 1'b0;
            re0        <= '0;
            im0        <= '0;
            v1         <= 1'b0;
            s1         <= 1'b0;
            dout_valid <= 1'b0;
            dout_sof   <= 1'b0;
            ovf        <= 1'b0;
        end else begin
            if (din_valid)
                cnt <= (coeff_addr == ADDR_W_S5'(N_COEFF_S5 - 1)) ? '0 : coeff_addr + 1'b1;
            v0         <= din_valid;
            s0         <= din_valid & din_sof;
            re0        <= din_re;
            im0        <= din_im;
            v1         <= v0;
            s1         <= s0;
            dout_valid <= v1;
            dout_sof   <= s1;
            // a saturating sof sample still flags: set wins over the frame clear
            if (v1)
                ovf <= sat_hit | (~s1 & ovf);
        end
    end

    cmult_rnd_sat u_cmult (
        .clk     (clk),
        .rst     (rst),
        .ld      (v1),
        .a_re    (re0),
        .a_im    (im0),
        .c_re    ($signed(coeff_in[2*COEFF_W-1:COEFF_W])),
        .c_im    ($signed(coeff_in[COEFF_W-1:0])),
        .y_re    (dout_re),
        .y_im    (dout_im),
        .sat_hit (sat_hit)
    );
endmodule
